// File: rtl/div_unit_pkg.sv
// Shared encodings and bus widths for the multi-cycle divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam int   DoubleRegBus      = 64;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider producing {remainder, quotient} for DIV/DIVU.
// Optional DIV_EARLY_OUT_EN finishes in two edges when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DoubleRegBus / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] divisor_q;
    logic             signed_q;
    logic             sign1_q;
    logic             sign2_q;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;
    logic             early;

    assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // quo_q starts as the dividend magnitude and shifts quotient bits in from the right.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, divisor_q};
    assign next_quo  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign next_rem  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign fix_quo   = (signed_q && (sign1_q ^ sign2_q)) ? -next_quo : next_quo;
    assign fix_rem   = (signed_q && sign1_q) ? -next_rem : next_rem;

`ifdef DIV_EARLY_OUT_EN
    assign early = (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DivFree;
            count     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            ready_o   <= DivResultNotReady;
            result_o  <= '0;
        end else begin
            case (state)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        signed_q <= signed_div_i;
                        if (opdata2_i == '0) begin
                            rem_q <= '0;
                            quo_q <= '0;
                            state <= DivByZero;
                        end else if (early) begin
                            // Early-out reuses the one-cycle BYZERO hop to keep two-edge latency.
                            rem_q <= opdata1_i;
                            quo_q <= '0;
                            state <= DivByZero;
                        end else begin
                            quo_q     <= mag1;
                            divisor_q <= mag2;
                            rem_q     <= '0;
                            sign1_q   <= opdata1_i[WIDTH-1];
                            sign2_q   <= opdata2_i[WIDTH-1];
                            count     <= '0;
                            state     <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else begin
                        state    <= DivEnd;
                        ready_o  <= DivResultReady;
                        result_o <= {rem_q, quo_q};
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                        count <= '0;
                    end else begin
                        count <= count + CW'(1);
                        quo_q <= next_quo;
                        rem_q <= next_rem;
                        if (count == CW'(WIDTH - 1)) begin
                            state    <= DivEnd;
                            ready_o  <= DivResultReady;
                            result_o <= {fix_rem, fix_quo};
                        end
                    end
                end
                DivEnd: begin
                    if (annul_i || start_i == DivStop) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule
